// File: rtl/syst_ws_array.sv
// Weight-stationary systolic array computing y = W*x for one input vector per cycle.
// Inputs are skewed into the columns, and row outputs are deskewed so every row emerges together.
module syst_ws_array #(
    parameter int ROWS    = 2,
    parameter int COLS    = 3,
    parameter int X_WIDTH = 8,
    parameter int W_WIDTH = 8,
    localparam int Y_WIDTH = X_WIDTH + W_WIDTH + $clog2(COLS),
    localparam int LAT     = ROWS + COLS,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     w_load_i,
    input  logic [RW-1:0]            w_row_i,
    input  logic [COLS*W_WIDTH-1:0]  w_data_i,
    output logic                     w_ready_o,
    input  logic                     x_valid_i,
    input  logic [COLS*X_WIDTH-1:0]  x_data_i,
    output logic                     x_ready_o,
    output logic                     y_valid_o,
    output logic [ROWS*Y_WIDTH-1:0]  y_data_o
);
    localparam int CW = $clog2(LAT + 1);

    logic                    accept;
    logic                    w_fire;
    logic [COLS*X_WIDTH-1:0] x_in;
    logic [X_WIDTH-1:0]      x_col [COLS];
    logic [ROWS*Y_WIDTH-1:0] row_res;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [LAT-1:0]          vld_q, vld_d;
    logic [ROWS*Y_WIDTH-1:0] y_q, y_d;
    logic [COLS*W_WIDTH-1:0] w_q [ROWS];
    logic [COLS*W_WIDTH-1:0] w_d [ROWS];
    logic [X_WIDTH-1:0]      x_q [ROWS][COLS];
    logic [X_WIDTH-1:0]      x_d [ROWS][COLS];
    logic [Y_WIDTH-1:0]      p_q [ROWS][COLS];
    logic [Y_WIDTH-1:0]      p_d [ROWS][COLS];

    // A weight write always wins over an input in the same cycle.
    assign x_ready_o = !w_load_i;
    assign accept    = x_valid_i && !w_load_i;
    assign w_ready_o = (cnt_q == '0);
    assign w_fire    = w_load_i && w_ready_o;
    assign x_in      = accept ? x_data_i : '0;
    assign y_valid_o = vld_q[LAT-1];
    assign y_data_o  = y_q;

    always_comb begin
        cnt_d = cnt_q + CW'(accept) - CW'(y_valid_o);
        vld_d = {vld_q[LAT-2:0], accept};
        y_d   = vld_q[LAT-2] ? row_res : y_q;
    end

    always_comb begin
        logic [X_WIDTH-1:0] xn;
        logic [Y_WIDTH-1:0] pin;
        xn  = '0;
        pin = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_d[r] = (w_fire && (w_row_i == RW'(r))) ? w_data_i : w_q[r];
            for (int c = 0; c < COLS; c++) begin
                if (r == 0) xn = x_col[c];
                else        xn = x_q[r-1][c];
                if (c == 0) pin = '0;
                else        pin = p_q[r][c-1];
                x_d[r][c] = xn;
                p_d[r][c] = pin + Y_WIDTH'(w_q[r][c*W_WIDTH +: W_WIDTH]) * Y_WIDTH'(xn);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            vld_q <= '0;
            y_q   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                w_q[r] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    x_q[r][c] <= '0;
                    p_q[r][c] <= '0;
                end
            end
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            y_q   <= y_d;
            w_q   <= w_d;
            x_q   <= x_d;
            p_q   <= p_d;
        end
    end

    // Column c sees its element c cycles late, matching the psum wavefront.
    for (genvar gc = 0; gc < COLS; gc++) begin : g_skew
        if (gc == 0) begin : g_direct
            assign x_col[gc] = x_in[0 +: X_WIDTH];
        end else begin : g_delay
            logic [X_WIDTH-1:0] s_q [gc];
            logic [X_WIDTH-1:0] s_d [gc];
            always_comb begin
                s_d[0] = x_in[gc*X_WIDTH +: X_WIDTH];
                for (int i = 1; i < gc; i++) s_d[i] = s_q[i-1];
            end
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < gc; i++) s_q[i] <= '0;
                end else begin
                    s_q <= s_d;
                end
            end
            assign x_col[gc] = s_q[gc-1];
        end
    end

    // Upper rows finish earlier; delay them so all rows line up with the last.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_deskew
        localparam int D = ROWS - 1 - gi;
        if (D == 0) begin : g_direct
            assign row_res[gi*Y_WIDTH +: Y_WIDTH] = p_q[gi][COLS-1];
        end else begin : g_delay
            logic [Y_WIDTH-1:0] d_q [D];
            logic [Y_WIDTH-1:0] d_d [D];
            always_comb begin
                d_d[0] = p_q[gi][COLS-1];
                for (int i = 1; i < D; i++) d_d[i] = d_q[i-1];
            end
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < D; i++) d_q[i] <= '0;
                end else begin
                    d_q <= d_d;
                end
            end
            assign row_res[gi*Y_WIDTH +: Y_WIDTH] = d_q[D-1];
        end
    end
endmodule

// File: tb/tb_syst_ws_array.sv
// Bench for syst_ws_array: directed scenarios plus random traffic against a dot-product model
// that tracks expected results and their due cycles in a queue.
module tb_syst_ws_array;
    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int XW   = 8;
    localparam int WW   = 8;
    localparam int YW   = XW + WW + $clog2(COLS);
    localparam int LAT  = ROWS + COLS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 w_load;
    logic [RW-1:0]        w_row;
    logic [COLS*WW-1:0]   w_data;
    logic                 w_ready;
    logic                 x_valid;
    logic [COLS*XW-1:0]   x_data;
    logic                 x_ready;
    logic                 y_valid;
    logic [ROWS*YW-1:0]   y_data;

    syst_ws_array #(.ROWS(ROWS), .COLS(COLS), .X_WIDTH(XW), .W_WIDTH(WW)) dut (
        .clk_i(clk), .rst_i(rst),
        .w_load_i(w_load), .w_row_i(w_row), .w_data_i(w_data), .w_ready_o(w_ready),
        .x_valid_i(x_valid), .x_data_i(x_data), .x_ready_o(x_ready),
        .y_valid_o(y_valid), .y_data_o(y_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        logic [ROWS*YW-1:0] y;
    } exp_t;

    int                 checks   = 0;
    int                 failures = 0;
    longint             wm [ROWS][COLS];
    exp_t               q [$];
    int                 cyc = 0;
    logic               exp_rdy = 1'b1;
    logic [ROWS*YW-1:0] last_y = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [23:0] pk(input int a, input int b, input int c);
        return {c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [ROWS*YW-1:0] ref_y(input logic [COLS*XW-1:0] xd);
        logic [ROWS*YW-1:0] y;
        longint s;
        y = '0;
        for (int r = 0; r < ROWS; r++) begin
            s = 0;
            for (int c = 0; c < COLS; c++) s += wm[r][c] * longint'(xd[c*XW +: XW]);
            y[r*YW +: YW] = YW'(s);
        end
        return y;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = 0;
        last_y  = '0;
        exp_rdy = 1'b1;
    endtask

    task automatic check_outputs();
        logic ev;
        exp_rdy = (q.size() == 0);
        chk("w_ready", 64'(w_ready), 64'(exp_rdy));
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("y_valid", 64'(y_valid), 64'(ev));
        if (ev) begin
            last_y = q[0].y;
            void'(q.pop_front());
        end
        chk("y_data", 64'(y_data), 64'(last_y));
    endtask

    // Drive one cycle of inputs, update the model at the edge, check after it.
    task automatic step(input logic wl, input int row, input logic [COLS*WW-1:0] wd,
                        input logic xv, input logic [COLS*XW-1:0] xd);
        w_load = wl; w_row = RW'(row); w_data = wd; x_valid = xv; x_data = xd;
        #1 chk("x_ready", 64'(x_ready), 64'(!wl));
        @(posedge clk);
        cyc++;
        if (wl && exp_rdy && row < ROWS)
            for (int c = 0; c < COLS; c++) wm[row][c] = longint'(wd[c*WW +: WW]);
        if (xv && !wl) q.push_back('{due: cyc + LAT - 1, y: ref_y(xd)});
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        w_load = 1'b0; x_valid = 1'b0;
        #1 model_reset();
        chk("rst_y_valid", 64'(y_valid), 64'd0);
        chk("rst_y_data",  64'(y_data),  64'd0);
        chk("rst_w_ready", 64'(w_ready), 64'd1);
        chk("rst_x_ready", 64'(x_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_y_data", 64'(y_data), 64'd0);
    endtask

    initial begin
        rst = 1'b1; w_load = 1'b0; w_row = '0; w_data = '0; x_valid = 1'b0; x_data = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Scenario 1: basic load and single vector.
        step(1'b1, 0, pk(2, 3, 4), 1'b0, '0);
        step(1'b1, 1, pk(5, 6, 7), 1'b0, '0);
        step(1'b0, 0, '0, 1'b1, pk(1, 1, 1));
        idle(LAT + 1);
        chk("t1_y", 64'(y_data), 64'({18'd18, 18'd9}));

        // Scenario 2: back-to-back vectors.
        step(1'b0, 0, '0, 1'b1, pk(1, 2, 3));
        step(1'b0, 0, '0, 1'b1, pk(0, 0, 0));
        step(1'b0, 0, '0, 1'b1, pk(10, 0, 1));
        step(1'b0, 0, '0, 1'b1, pk(255, 255, 255));
        idle(LAT + 1);
        chk("t2_y", 64'(y_data), 64'({18'd4590, 18'd2295}));

        // Scenario 3: full-scale operands.
        step(1'b1, 0, pk(255, 255, 255), 1'b0, '0);
        step(1'b1, 1, pk(255, 255, 255), 1'b0, '0);
        step(1'b0, 0, '0, 1'b1, pk(255, 255, 255));
        idle(LAT + 1);
        chk("t3_y_max", 64'(y_data), 64'({18'd195075, 18'd195075}));
        step(1'b0, 0, '0, 1'b1, pk(0, 0, 0));
        idle(LAT + 1);

        // Scenario 4: simultaneous load and input while idle; vector retried next cycle.
        step(1'b1, 0, pk(1, 1, 1), 1'b1, pk(3, 4, 5));
        step(1'b0, 0, '0, 1'b1, pk(3, 4, 5));
        idle(LAT + 1);
        chk("t4_y", 64'(y_data), 64'({18'd3060, 18'd12}));

        // Scenario 5: load held while a vector is in flight.
        step(1'b0, 0, '0, 1'b1, pk(2, 2, 2));
        for (int i = 0; i < LAT + 2; i++) step(1'b1, 1, pk(1, 2, 3), 1'b0, '0);
        idle(1);
        step(1'b0, 0, '0, 1'b1, pk(1, 1, 1));
        idle(LAT + 1);
        chk("t5_y", 64'(y_data), 64'({18'd6, 18'd3}));

        // Scenario 6: reset with a vector in flight.
        step(1'b0, 0, '0, 1'b1, pk(9, 9, 9));
        idle(1);
        @(negedge clk);
        do_reset();
        idle(LAT + 2);
        step(1'b0, 0, '0, 1'b1, pk(1, 1, 1));
        idle(LAT + 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic wl, xv;
            wl = ($urandom_range(0, 7) == 0);
            xv = ($urandom_range(0, 3) != 0);
            step(wl, int'($urandom_range(0, ROWS - 1)), COLS*WW'($urandom),
                 xv, COLS*XW'($urandom));
        end
        idle(LAT + 2);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/syst_ws_array.md
Name: syst_ws_array

Overview:
- Parametrised weight-stationary systolic array computing y = W·x (ROWS×COLS unsigned weights, COLS-element input vector).
- Successor to the fixed 2×3 array: generic dimensions, runtime weight loading, internal input skew and output deskew, valid/ready handshake.
- Accepts one vector per cycle. Feeds downstream accumulator/activation stages that have no backpressure.

Parameters:
ROWS, 2, number of output channels (array rows), ≥1
COLS, 3, number of input elements (array columns), ≥1
X_WIDTH, 8, unsigned input element width
W_WIDTH, 8, unsigned weight width
Y_WIDTH (derived localparam), X_WIDTH+W_WIDTH+$clog2(COLS) (min +0 when COLS=1), output width
LAT (derived localparam), ROWS+COLS, accept-to-output latency in cycles

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
w_load_i  in  1  write one weight row this cycle
w_row_i  in  max(1,$clog2(ROWS))  row index for weight write
w_data_i  in  COLS*W_WIDTH  weight row; element c at [c*W_WIDTH +: W_WIDTH]
w_ready_o  out  1  weight write permitted
x_valid_i  in  1  input vector valid
x_data_i  in  COLS*X_WIDTH  input vector; element c at [c*X_WIDTH +: X_WIDTH]
x_ready_o  out  1  input vector accepted when high with x_valid_i
y_valid_o  out  1  result valid, single-cycle pulse per vector
y_data_o  out  ROWS*Y_WIDTH  result; row r at [r*Y_WIDTH +: Y_WIDTH]

Behaviour:
- Reset (async assert, sync-safe release) clears all weight regs, skew/deskew regs, node psum/x regs, valid chain, in-flight counter and y_data_o to 0. Outputs in reset: y_valid_o=0, y_data_o=0, w_ready_o=1, x_ready_o=1.
- Weight write: fires when w_load_i && w_ready_o.
  - Row w_row_i takes w_data_i at the edge.
  - w_row_i ≥ ROWS is ignored; no state change.
  - w_ready_o = (in-flight count == 0), registered-count based.
  - Weights therefore never change while a vector is in flight.
- Input accept: fires when x_valid_i && x_ready_o.
  - x_ready_o = !w_load_i (combinational). A weight write takes priority over an input in the same cycle.
  - A rejected x_valid_i is not captured; the source holds it.
- In-flight counter:
  - +1 on accept, −1 on y_valid_o.
  - Both in the same cycle: no change.
  - Range 0..LAT; never overflows because output is one-per-cycle.
- Datapath:
  - Input skew: element c delayed c cycles before column c.
  - Node (r,c), registered: psum_out = psum_in + w[r][c]*x.
    - psum_in = 0 for c=0.
    - x is forwarded registered to row r+1.
  - Row r output is deskewed by ROWS−1−r cycles so all rows align.
- Arithmetic: full-precision unsigned; no truncation or saturation. Result ≤ COLS·(2^X_WIDTH−1)·(2^W_WIDTH−1) fits Y_WIDTH.
- Timing:
  - Valid shift chain of length LAT mirrors accepts.
  - Vector accepted at edge k gives y_valid_o=1 in the cycle following edge k+LAT−1, i.e. LAT cycles later.
  - Back-to-back accepts give back-to-back results; input bubbles give y_valid_o=0 in the matching cycles.
- y_data_o is registered and loaded only when the result is valid; it holds the last valid result otherwise.
- Reset mid-operation: all in-flight vectors are discarded, no y_valid_o is produced for them, and weights return to 0.
- No output backpressure; the consumer must accept every y_valid_o pulse.

Test Plan:
1. Defaults; reset; load row0=[2,3,4], row1=[5,6,7]; send x=[1,1,1] → after 5 cycles y_valid_o pulse, y1=9, y2=18; w_ready_o low for those 5 cycles.
2. Same weights; 4 back-to-back vectors [1,2,3],[0,0,0],[10,0,1],[255,255,255] → 4 consecutive valid cycles: (20,38),(0,0),(24,57),(2295,4590).
3. All weights 255, x=[255,255,255] → y=195075 on both rows (18-bit, no overflow). Then x=[0,0,0] → 0.
4. Assert w_load_i and x_valid_i together while idle → weight written, x_ready_o=0, vector retained. Next cycle the vector is accepted and its result uses the new weight.
5. w_load_i while a vector is in flight → w_ready_o=0, weights unchanged, result matches old weights. Write succeeds the cycle after the count reaches 0.
6. Assert rst_i 2 cycles after accepting a vector → no y_valid_o ever appears for it. After release, y_data_o=0, w_ready_o=1, and x=[1,1,1] yields y=(0,0).
